// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the 6502 bus-side register logic.
// Fetches bytes with a three-state read handshake and presents them first-word-fall-through.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic                  rx_read,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [1:0]            state_r;
  logic                  rx_read_r;
  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  overrun_r;

  logic push_s;
  logic pop_s;
  logic wr_en_s;
  logic drop_s;
  logic empty_s;
  logic full_s;

  assign empty_s = (count_r == {(DEPTH_LOG2+1){1'b0}});
  assign full_s  = (count_r == FULL_COUNT);
  assign push_s  = (state_r == ST_CAPT);
  assign pop_s   = cpu_rd && !empty_s;
  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Fetch FSM: IDLE -> REQ (rx_read strobe) -> CAPT (sample rx_data) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rx_read_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_ready) begin
            state_r   <= ST_REQ;
            rx_read_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            rx_read_r <= 1'b0;
          end
        end
        ST_REQ: begin
          state_r   <= ST_CAPT;
          rx_read_r <= 1'b0;
        end
        ST_CAPT: begin
          state_r   <= ST_IDLE;
          rx_read_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          rx_read_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; no reset needed since contents are only visible when count > 0.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Pointers, occupancy and the sticky overrun flag (a new drop beats a clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r  <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r  <= {DEPTH_LOG2{1'b0}};
      count_r   <= {(DEPTH_LOG2+1){1'b0}};
      overrun_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign rx_read  = rx_read_r;
  assign cpu_dout = mem_r[rd_ptr_r];
  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH_LOG2=2) with a receiver model
// and a queue-based reference of FIFO contents and the overrun flag.
module tb_uart_rx_fifo;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_ready = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_read;
  logic         cpu_rd = 1'b0;
  logic [7:0]   cpu_dout;
  logic         empty;
  logic         full;
  logic [DL2:0] count;
  logic         overrun;
  logic         clr_overrun = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // receiver-side byte waiting to be read, plus reference model state
  logic [7:0] rx_hold = 8'h00;
  logic [7:0] model_q[$];
  logic       model_ov = 1'b0;
  logic       capt_pending = 1'b0;
  logic [7:0] last_pop = 8'h00;
  int         cyc = 0;

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_read(rx_read), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .empty(empty),
    .full(full), .count(count), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // One clock: update the reference from this cycle's inputs, then move the receiver.
  task automatic cycle();
    logic rd, pop, capt_now, clr, rst, full_before, drop;
    logic [7:0] cap_byte;
    rd = rx_read; pop = cpu_rd; capt_now = capt_pending; clr = clr_overrun;
    rst = reset; cap_byte = rx_data;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_ov = 1'b0;
      capt_pending = 1'b0;
    end else begin
      drop = 1'b0;
      full_before = (model_q.size() == DEPTH);
      if (pop && model_q.size() > 0) last_pop = model_q.pop_front();
      if (capt_now) begin
        if (!full_before || pop) model_q.push_back(cap_byte);
        else drop = 1'b1;
      end
      if (drop) model_ov = 1'b1;
      else if (clr) model_ov = 1'b0;
      capt_pending = rd;
    end
    #1;
    if (rd) begin
      rx_data = rx_hold;
      rx_ready = 1'b0;
    end else begin
      rx_data = 8'h00;
    end
    cpu_rd = 1'b0;
    clr_overrun = 1'b0;
    cyc++;
  endtask

  task automatic deliver(input logic [7:0] b);
    rx_hold = b;
    rx_ready = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_ready = 1'b1; rx_hold = 8'h77;
    repeat (3) cycle();
    tests_run++; if (rx_read !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_read: got %0b expected 0", rx_read); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b expected 0", full); end
    reset = 1'b0;
    cycle();
    tests_run++; if (rx_read !== 1'b1) begin tests_failed++; $display("FAIL reset_fetch_start: got %0b expected 1", rx_read); end
    cycle();
    tests_run++; if (rx_read !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_one_cycle: got %0b expected 0", rx_read); end
    cycle();
    tests_run++; if (count !== 3'd1 || cpu_dout !== 8'h77) begin tests_failed++; $display("FAIL reset_pending_byte: got count=%0d dout=%h expected 1/77", count, cpu_dout); end
    cpu_rd = 1'b1; cycle();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_drain: got empty=%0b expected 1", empty); end
  endtask

  task automatic test_single();
    rx_hold = 8'h5A; rx_ready = 1'b1;
    cycle();
    tests_run++; if (rx_read !== 1'b1) begin tests_failed++; $display("FAIL single_req: got %0b expected 1", rx_read); end
    cycle();
    tests_run++; if (rx_read !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL single_capt: got rx_read=%0b empty=%0b expected 0/1", rx_read, empty); end
    cycle();
    tests_run++; if (empty !== 1'b0 || count !== 3'd1 || cpu_dout !== 8'h5A) begin tests_failed++; $display("FAIL single_stored: got empty=%0b count=%0d dout=%h expected 0/1/5a", empty, count, cpu_dout); end
    cpu_rd = 1'b1; cycle();
    tests_run++; if (empty !== 1'b1 || count !== 3'd0) begin tests_failed++; $display("FAIL single_pop: got empty=%0b count=%0d expected 1/0", empty, count); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_order [4];
    exp_order[0] = 8'h03; exp_order[1] = 8'h04; exp_order[2] = 8'h05; exp_order[3] = 8'h06;
    for (int i = 1; i <= 4; i++) deliver(8'(i));
    tests_run++; if (full !== 1'b1 || count !== 3'd4) begin tests_failed++; $display("FAIL wrap_full: got full=%0b count=%0d expected 1/4", full, count); end
    tests_run++; if (cpu_dout !== 8'h01) begin tests_failed++; $display("FAIL wrap_head1: got %h expected 01", cpu_dout); end
    cpu_rd = 1'b1; cycle();
    tests_run++; if (cpu_dout !== 8'h02) begin tests_failed++; $display("FAIL wrap_head2: got %h expected 02", cpu_dout); end
    cpu_rd = 1'b1; cycle();
    deliver(8'h05);
    deliver(8'h06);
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (cpu_dout !== exp_order[i] || empty !== 1'b0) begin tests_failed++; $display("FAIL wrap_order%0d: got %h empty=%0b expected %h", i, cpu_dout, empty, exp_order[i]); end
      cpu_rd = 1'b1; cycle();
    end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 4; i++) deliver(8'(8'h10 + i));
    deliver(8'h14);
    tests_run++; if (overrun !== 1'b1 || count !== 3'd4 || cpu_dout !== 8'h10) begin tests_failed++; $display("FAIL ovr_drop: got ovr=%0b count=%0d head=%h expected 1/4/10", overrun, count, cpu_dout); end
    rx_hold = 8'h15; rx_ready = 1'b1;
    cycle(); cycle();
    clr_overrun = 1'b1; cycle();
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set_wins: got %0b expected 1", overrun); end
    clr_overrun = 1'b1; cycle();
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (cpu_dout !== 8'(8'h10 + i)) begin tests_failed++; $display("FAIL ovr_content%0d: got %h expected %h", i, cpu_dout, 8'(8'h10 + i)); end
      cpu_rd = 1'b1; cycle();
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) deliver(8'(8'h30 + i));
    rx_hold = 8'h20; rx_ready = 1'b1;
    cycle(); cycle();
    cpu_rd = 1'b1; cycle();
    tests_run++; if (count !== 3'd4 || overrun !== 1'b0 || full !== 1'b1) begin tests_failed++; $display("FAIL fpp_count: got count=%0d ovr=%0b full=%0b expected 4/0/1", count, overrun, full); end
    tests_run++; if (cpu_dout !== 8'h31) begin tests_failed++; $display("FAIL fpp_head: got %h expected 31", cpu_dout); end
    repeat (4) begin cpu_rd = 1'b1; cycle(); end
    tests_run++; if (last_pop !== 8'h20 || empty !== 1'b1) begin tests_failed++; $display("FAIL fpp_last: got last=%h empty=%0b expected 20/1", last_pop, empty); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = 0; t2 = 0;
    cpu_rd = 1'b1; cycle();
    tests_run++; if (count !== 3'd0 || empty !== 1'b1 || overrun !== 1'b0) begin tests_failed++; $display("FAIL underflow: got count=%0d empty=%0b ovr=%0b expected 0/1/0", count, empty, overrun); end
    rx_hold = 8'hA1; rx_ready = 1'b1;
    cycle(); if (rx_read === 1'b1) t1 = cyc;
    cycle();
    rx_hold = 8'hA2; rx_ready = 1'b1;
    cycle();
    cycle(); if (rx_read === 1'b1) t2 = cyc;
    tests_run++; if (t1 == 0 || t2 - t1 != 3) begin tests_failed++; $display("FAIL b2b_spacing: got t1=%0d t2=%0d expected spacing 3", t1, t2); end
    cycle(); cycle();
    tests_run++; if (count !== 3'd2 || cpu_dout !== 8'hA1) begin tests_failed++; $display("FAIL b2b_first: got count=%0d dout=%h expected 2/a1", count, cpu_dout); end
    cpu_rd = 1'b1; cycle();
    tests_run++; if (cpu_dout !== 8'hA2 || count !== 3'd1) begin tests_failed++; $display("FAIL b2b_second: got dout=%h count=%0d expected a2/1", cpu_dout, count); end
    cpu_rd = 1'b1; cycle();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      if (!rx_ready && $urandom_range(1, 0) == 1) begin
        rx_hold = 8'($urandom);
        rx_ready = 1'b1;
      end
      cpu_rd = ($urandom_range(3, 0) == 0);
      clr_overrun = ($urandom_range(15, 0) == 0);
      reset = ($urandom_range(63, 0) == 0);
      cycle();
      reset = 1'b0;
      tests_run++;
      if (count !== 3'(model_q.size()) || empty !== (model_q.size() == 0) ||
          full !== (model_q.size() == DEPTH) || overrun !== model_ov ||
          (model_q.size() > 0 && cpu_dout !== model_q[0])) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: got count=%0d empty=%0b full=%0b ovr=%0b dout=%h expected count=%0d ovr=%0b head=%h",
                   n, count, empty, full, overrun, cpu_dout, model_q.size(), model_ov,
                   (model_q.size() > 0) ? model_q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_overrun();
    test_full_pushpop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver; drains each received byte via the receiver's ready/read handshake.
- Stores bytes in a small FIFO and presents them first-word-fall-through to the 6502 bus-side register logic.
- Flags overrun when a byte arrives with the FIFO full.
- Decouples CPU polling latency from line rate, so back-to-back characters are not lost while the CPU is busy.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..8.

Ports:
- clk  input  1  system clock, same clock as the UART receiver
- reset  input  1  synchronous, active-high reset
- rx_ready  input  1  receiver "byte available" flag (receiver ready output)
- rx_data  input  8  receiver data output; valid only the cycle after rx_read is high, otherwise 0
- rx_read  output  1  one-cycle strobe to the receiver's read input
- cpu_rd  input  1  pop strobe from bus logic, one cycle per byte
- cpu_dout  output  8  head-of-FIFO byte, valid when empty=0
- empty  output  1  FIFO holds no bytes
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
- count  output  DEPTH_LOG2+1  number of stored bytes
- overrun  output  1  sticky: byte dropped because FIFO was full
- clr_overrun  input  1  clears overrun

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, rx_read=0, FSM=IDLE. cpu_dout is don't-care while empty.
- Reset mid-handshake: return to IDLE immediately and drop any in-flight byte. A byte still pending in the receiver, with rx_ready=1, is fetched after reset deasserts.
- Fetch FSM, registered rx_read:
  - IDLE: if rx_ready=1, go to REQ.
  - REQ: rx_read=1 for exactly this cycle; the receiver clears ready and loads rx_data at the end of the cycle. Go to CAPT.
  - CAPT: rx_read=0; sample rx_data and issue a push at the end of the cycle. Go to IDLE.
  - The FSM ignores rx_ready outside IDLE. A byte the receiver completes during REQ/CAPT keeps rx_ready high and is fetched on return to IDLE.
  - Throughput: one byte per 3 clocks, far above any line rate.
- Push (end of CAPT):
  - If full=0, or full=1 with a simultaneous pop: write mem[wr_ptr], wr_ptr+1.
  - If full=1 with no pop: discard the byte and set overrun=1. Pointers and count are unchanged.
- Pop (cpu_rd=1):
  - If empty=0: rd_ptr+1.
  - If empty=1: ignored, no state change, no error flag.
- count arithmetic:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - empty = (count==0); full = (count==2**DEPTH_LOG2). Both are derived from registered count, so they are valid the cycle after the event.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth with no special case at the wrap boundary.
- cpu_dout = mem[rd_ptr], combinational read of the register array. A byte pushed into an empty FIFO appears on cpu_dout the cycle after CAPT, when empty falls. After a pop, the next byte appears the following cycle.
- overrun:
  - Set by a dropped push; cleared by clr_overrun.
  - If set and clear occur in the same cycle, set wins (overrun stays 1).
  - overrun does not block further pushes once space frees.

Test Plan:
- Reset with rx_ready=1 held: during reset rx_read=0, empty=1, count=0, overrun=0. After deassert, rx_read pulses for exactly 1 cycle starting 1 cycle later.
- Single byte: receiver delivers 0x5A → rx_read pulse, then rx_data=0x5A sampled in CAPT. Next cycle: empty=0, count=1, cpu_dout=0x5A. Pulse cpu_rd → empty=1, count=0.
- Ordering and wrap (DEPTH_LOG2=2): push 0x01..0x04 → full=1. Pop 2 (cpu_dout 0x01, then 0x02). Push 0x05, 0x06 → pop order is 0x03, 0x04, 0x05, 0x06, then empty=1.
- Overrun (DEPTH_LOG2=2): fill with 0x10..0x13, then deliver 0x14 → overrun=1, count=4, head stays 0x10. Assert clr_overrun and a new drop in the same cycle → overrun stays 1. Next clr_overrun alone → overrun=0.
- Full with simultaneous push and pop: count=4; pop lands in CAPT cycle of byte 0x20 → count stays 4, no overrun, 0x20 is the last entry popped.
- Underflow and back-to-back: cpu_rd while empty → no change. Receiver raises ready again during CAPT (bytes 0xA1, 0xA2) → both stored in order, rx_read pulses 3 cycles apart.
